// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: word-addressed RAM behind an in-order response queue
// with a fixed, programmable latency from address handshake to data_ok.
module data_sram_responder #(
    parameter int unsigned AW      = 12,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    input  logic        stall_inject,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned TW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned WORDS = 1 << AW;

    typedef struct packed {
        logic          is_write;
        logic [31:0]   rdata;
        logic [TW-1:0] timer;
    } entry_t;

    logic [31:0]      ram [WORDS];
    entry_t           q [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic             resetn_q;
    logic             full;
    logic             accept;
    logic             pop;
    logic [AW-1:0]    word_idx;
    logic             unused_bits;

    // Size and byte offset carry no meaning here; high address bits alias.
    assign unused_bits = ^{data_sram_size, data_sram_addr[1:0], data_sram_addr[31:AW+2]};

    assign word_idx          = data_sram_addr[AW+1:2];
    assign full              = (count == CW'(DEPTH));
    assign data_sram_addr_ok = resetn_q && !full && !stall_inject;
    assign accept            = data_sram_req && data_sram_addr_ok && resetn;
    assign pop               = q_valid[head] && (q[head].timer == '0);

    // Response side: head entry whose latency has expired, rdata zeroed otherwise.
    always_comb begin
        data_sram_data_ok = pop;
        data_sram_rdata   = 32'h0;
        if (pop && !q[head].is_write) begin
            data_sram_rdata = q[head].rdata;
        end
    end

    // Byte-lane RAM write on accept; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wstrb[2'(i)]) begin
                    ram[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Outstanding-request queue: enqueue on accept, age timers, pop the head.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            resetn_q <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            q_valid  <= '0;
        end else begin
            resetn_q <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (q_valid[PW'(i)] && (q[PW'(i)].timer != '0)) begin
                    q[PW'(i)].timer <= q[PW'(i)].timer - TW'(1);
                end
            end
            if (pop) begin
                q_valid[head] <= 1'b0;
                head          <= head + PW'(1);
            end
            if (accept) begin
                q[tail].is_write <= data_sram_wr;
                q[tail].rdata    <= data_sram_wr ? 32'h0 : ram[word_idx];
                q[tail].timer    <= TW'(LATENCY - 1);
                q_valid[tail]    <= 1'b1;
                tail             <= tail + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: two instances (latency 2 and 6), random and
// directed traffic, scoreboard fed at acceptance and drained by the response monitor.
module tb_data_sram_responder;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             resetn;
    logic [1:0]       req, wr, stall, addr_ok, data_ok;
    logic [1:0][1:0]  size;
    logic [1:0][3:0]  wstrb;
    logic [1:0][31:0] addr, wdata, rdata;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_wr;
        logic [31:0] data;
        int          due;
    } resp_t;

    function automatic void check(input string name, input int inst,
                                  input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s[%0d] cycle %0d: got %h expected %h", name, inst, cyc, got, exp);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned LAT = (g == 0) ? 2 : 6;

        resp_t       exp_q[$];
        logic [31:0] mem [int];
        int          last_due = 0;
        bit          armed    = 0;
        bit          rstq_m   = 0;

        data_sram_responder #(.AW(AW), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
            .clk               (clk),
            .resetn            (resetn),
            .data_sram_req     (req[g]),
            .data_sram_wr      (wr[g]),
            .data_sram_size    (size[g]),
            .data_sram_wstrb   (wstrb[g]),
            .data_sram_addr    (addr[g]),
            .data_sram_wdata   (wdata[g]),
            .stall_inject      (stall[g]),
            .data_sram_addr_ok (addr_ok[g]),
            .data_sram_data_ok (data_ok[g]),
            .data_sram_rdata   (rdata[g])
        );

        // Reference: in-order responses, each due at max(accept+LAT, previous due+1).
        always @(negedge clk) begin : monitor
            bit          exp_ok;
            resp_t       e;
            logic [32:0] want;
            int          idx;
            logic [31:0] w;
            if (armed) begin
                exp_ok = rstq_m && (exp_q.size() < int'(DEPTH)) && !stall[g];
                check("addr_ok", g, 64'(addr_ok[g]), 64'(exp_ok));
                want = 33'h0;
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    e    = exp_q.pop_front();
                    want = {1'b1, (e.is_wr ? 32'h0 : e.data)};
                end
                check("data_ok_rdata", g, 64'({data_ok[g], rdata[g]}), 64'(want));
                if (!resetn) begin
                    exp_q.delete();
                    last_due = 0;
                end else if (req[g] && exp_ok) begin
                    idx   = int'(addr[g][AW+1:2]);
                    e.due = (cyc + int'(LAT) > last_due + 1) ? cyc + int'(LAT) : last_due + 1;
                    last_due = e.due;
                    e.is_wr  = wr[g];
                    w = mem.exists(idx) ? mem[idx] : 32'h0;
                    if (wr[g]) begin
                        for (int b = 0; b < 4; b++)
                            if (wstrb[g][b]) w[8*b +: 8] = wdata[g][8*b +: 8];
                        mem[idx] = w;
                    end
                    e.data = w;
                    exp_q.push_back(e);
                end
            end
            if (!resetn) armed = 1;
            rstq_m = resetn;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic issue(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [1:0] sz, input int stall_cyc);
        int n = 0;
        req[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d; wstrb[i] = s; size[i] = sz;
        if (stall_cyc > 0) begin
            stall[i] = 1'b1;
            idle(stall_cyc);
            stall[i] = 1'b0;
        end
        do begin
            @(negedge clk);
            n++;
        end while (addr_ok[i] !== 1'b1 && n < 100);
        if (n >= 100) begin
            n_checks++;
            $display("FAIL accept_timeout[%0d]: addr_ok=%b after %0d cycles, expected 1", i, addr_ok[i], n);
        end
        @(posedge clk); #1;
        req[i] = 1'b0;
    endtask

    task automatic write(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        issue(i, 1'b1, a, d, s, 2'd2, 0);
    endtask

    task automatic read(input int i, input logic [31:0] a);
        issue(i, 1'b0, a, 32'h0, 4'h0, 2'd2, 0);
    endtask

    task automatic rand_ops(input int i, input int n, input int nwords);
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            a = $urandom;
            a[AW+1:2] = AW'($urandom_range(0, nwords - 1));
            issue(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 2'($urandom_range(0, 2)),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
            idle(int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        resetn = 1'b0; req = '0; wr = '0; stall = '0;
        size = '0; wstrb = '0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Single write/read, then byte/half strobe merge on word 0x100.
        write(0, 32'h100, 32'h12345678, 4'b1111);
        read(0, 32'h100);
        write(0, 32'h101, 32'hABABABAB, 4'b0010);
        write(0, 32'h102, 32'hCDCDCDCD, 4'b1100);
        read(0, 32'h100);

        // Fill words 0..15, then back-to-back reads.
        for (int k = 0; k < 16; k++) write(0, 32'(k * 4), $urandom, 4'hF);
        for (int k = 0; k < 4; k++) read(0, 32'(k * 4));

        // Request held through a 3-cycle stall.
        issue(0, 1'b0, 32'h8, 32'h0, 4'h0, 2'd2, 3);
        idle(5);
        rand_ops(0, 150, 16);
        idle(10);

        // Latency 6: continuous requests overrun the 4-entry queue.
        for (int k = 0; k < 8; k++) write(1, 32'(k * 4), $urandom, 4'hF);
        for (int k = 0; k < 8; k++) read(1, 32'(k * 4));
        idle(15);
        rand_ops(1, 40, 8);
        idle(15);

        // Reset with two reads in flight; RAM must keep its contents.
        write(1, 32'h40, 32'hCAFEF00D, 4'hF);
        idle(10);
        read(1, 32'h40);
        read(1, 32'h0);
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
        idle(12);
        read(1, 32'h40);
        read(0, 32'h100);
        idle(15);

        check("drain", 0, 64'(g_inst[0].exp_q.size()), 64'd0);
        check("drain", 1, 64'(g_inst[1].exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
